// File: rtl/fpga_spi_cmd_master_if.sv
// rtl/fpga_spi_cmd_master_if.sv - command handshake and SPI pin bundle for fpga_spi_cmd_master
interface fpga_spi_cmd_master_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [15:0] cmd_word;
  logic        spck;
  logic        mosi;
  logic        ncs;
  logic        busy;
  logic        done;

  modport master (
    input  cmd_valid, cmd_word,
    output cmd_ready, spck, mosi, ncs, busy, done
  );

  modport slave (
    output cmd_valid, cmd_word,
    input  cmd_ready, spck, mosi, ncs, busy, done
  );
endinterface

// File: rtl/fpga_spi_cmd_master.sv
// rtl/fpga_spi_cmd_master.sv - SPI mode-0 initiator sending 16-bit command words MSB first
module fpga_spi_cmd_master #(
  parameter int CLK_DIV  = 4,
  parameter int NCS_IDLE = 8
) (
  input  logic                  pck0,
  input  logic                  reset,
  fpga_spi_cmd_master_if.master bus
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, TRAIL, GAP} state_t;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LOAD = 8'(NCS_IDLE);

  state_t      state;
  logic [7:0]  cnt;
  logic [3:0]  bit_idx;
  logic [15:0] word_q;
  logic        trail_hold;
  logic        spck_q, mosi_q, ncs_q, busy_q, done_q, ready_q;
  logic        cnt_zero;
  logic [3:0]  next_idx;

  assign cnt_zero = (cnt == 8'd0);
  assign next_idx = bit_idx + 4'd1;

  assign bus.cmd_ready = ready_q;
  assign bus.spck      = spck_q;
  assign bus.mosi      = mosi_q;
  assign bus.ncs       = ncs_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

  always_ff @(posedge pck0) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      bit_idx    <= 4'd0;
      word_q     <= 16'd0;
      trail_hold <= 1'b0;
      spck_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ncs_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ready_q && bus.cmd_valid) begin
            word_q     <= bus.cmd_word;
            mosi_q     <= bus.cmd_word[15];
            ncs_q      <= 1'b0;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
            bit_idx    <= 4'd0;
            trail_hold <= 1'b0;
            cnt        <= DIV_LOAD;
            state      <= SETUP;
          end else begin
            ready_q <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt_zero) begin
            spck_q <= 1'b1;
            cnt    <= DIV_LOAD;
            state  <= HIGH;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        HIGH: begin
          if (cnt_zero) begin
            spck_q <= 1'b0;
            cnt    <= DIV_LOAD;
            if (bit_idx == 4'd15) begin
              mosi_q <= 1'b0;
              state  <= TRAIL;
            end else begin
              // bit index counts from the MSB, so ~idx selects bit 15-idx
              mosi_q  <= word_q[~next_idx];
              bit_idx <= next_idx;
              state   <= LOW;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        LOW: begin
          if (cnt_zero) begin
            spck_q <= 1'b1;
            cnt    <= DIV_LOAD;
            state  <= HIGH;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        TRAIL: begin
          // Two half-periods: the low phase after bit 15, then the ncs hold-off.
          if (cnt_zero) begin
            if (!trail_hold) begin
              trail_hold <= 1'b1;
              cnt        <= DIV_LOAD;
            end else begin
              ncs_q  <= 1'b1;
              done_q <= 1'b1;
              cnt    <= GAP_LOAD;
              state  <= GAP;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          if (cnt_zero) begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_spi_cmd_master.sv
// tb/tb_fpga_spi_cmd_master.sv - bench for fpga_spi_cmd_master with SPI receiver model and protocol monitor
module tb_fpga_spi_cmd_master;

  logic pck0 = 1'b0;
  always #5 pck0 = ~pck0;

  logic reset_a, reset_b;
  fpga_spi_cmd_master_if bus_a ();
  fpga_spi_cmd_master_if bus_b ();

  fpga_spi_cmd_master #(.CLK_DIV(4), .NCS_IDLE(8)) dut_a (
    .pck0 (pck0), .reset(reset_a), .bus(bus_a.master)
  );
  fpga_spi_cmd_master #(.CLK_DIV(1), .NCS_IDLE(1)) dut_b (
    .pck0 (pck0), .reset(reset_b), .bus(bus_b.master)
  );

  int div_k[2]  = '{4, 1};
  int idle_k[2] = '{8, 1};

  logic sp[2], mo[2], nc[2], dn[2], vl[2], rdy[2], bz[2], rs[2];
  assign sp[0]  = bus_a.spck;      assign sp[1]  = bus_b.spck;
  assign mo[0]  = bus_a.mosi;      assign mo[1]  = bus_b.mosi;
  assign nc[0]  = bus_a.ncs;       assign nc[1]  = bus_b.ncs;
  assign dn[0]  = bus_a.done;      assign dn[1]  = bus_b.done;
  assign vl[0]  = bus_a.cmd_valid; assign vl[1]  = bus_b.cmd_valid;
  assign rdy[0] = bus_a.cmd_ready; assign rdy[1] = bus_b.cmd_ready;
  assign bz[0]  = bus_a.busy;      assign bz[1]  = bus_b.busy;
  assign rs[0]  = reset_a;         assign rs[1]  = reset_b;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge pck0) cyc <= cyc + 1;

  logic        psp[2] = '{1'b0, 1'b0};
  logic        pmo[2] = '{1'b0, 1'b0};
  logic        pnc[2] = '{1'b1, 1'b1};
  logic [15:0] rx_word[2] = '{16'd0, 16'd0};
  logic [15:0] last_word[2] = '{16'd0, 16'd0};
  logic [7:0]  conf[2] = '{8'd0, 8'd0};
  int          rx_bits[2] = '{0, 0};
  int          low_cnt[2] = '{0, 0};
  int          high_cnt[2] = '{1000, 1000};
  int          last_low[2] = '{0, 0};
  int          last_bits[2] = '{0, 0};
  int          frames[2] = '{0, 0};
  int          acc_cnt[2] = '{0, 0};
  int          done_cyc[2] = '{0, 0};
  int          gap_acc[2] = '{0, 0};
  logic        done_at_rise[2] = '{1'b0, 1'b0};
  logic        busy_at_rise[2] = '{1'b0, 1'b0};
  logic        have_done[2] = '{1'b0, 1'b0};
  logic        skip_gap[2] = '{1'b1, 1'b1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Receiver model plus protocol monitor, sampled on the falling edge.
  always @(negedge pck0) begin
    for (int k = 0; k < 2; k++) begin
      if (rs[k]) begin
        have_done[k] = 1'b0;
        skip_gap[k]  = 1'b1;
      end else if (vl[k] && rdy[k]) begin
        acc_cnt[k]++;
        if (have_done[k]) begin
          gap_acc[k] = cyc - done_cyc[k];
          chk($sformatf("accept_spacing[%0d]", k), 32'(gap_acc[k] >= idle_k[k] + 1), 32'd1);
        end
      end
      if (sp[k] && !psp[k] && !nc[k]) begin
        rx_word[k] = {rx_word[k][14:0], mo[k]};
        rx_bits[k]++;
      end
      if (sp[k] && psp[k])
        chk($sformatf("mosi_stable_spck_high[%0d]", k), 32'(mo[k]), 32'(pmo[k]));
      if (sp[k] !== psp[k] && psp[k] !== 1'bx)
        chk($sformatf("spck_toggle_ncs_high[%0d]", k), 32'(nc[k] && pnc[k]), 32'd0);
      if (nc[k] === 1'b0 && pnc[k] === 1'b1) begin
        chk($sformatf("spck_at_ncs_fall[%0d]", k), 32'(sp[k]), 32'd0);
        if (!skip_gap[k])
          chk($sformatf("ncs_idle_len[%0d]", k), 32'(high_cnt[k] >= idle_k[k]), 32'd1);
        skip_gap[k] = 1'b0;
        low_cnt[k]  = 1;
        rx_bits[k]  = 0;
      end else if (nc[k] === 1'b0) begin
        low_cnt[k]++;
      end
      if (nc[k] === 1'b1 && pnc[k] === 1'b0) begin
        chk($sformatf("spck_at_ncs_rise[%0d]", k), 32'(sp[k]), 32'd0);
        last_low[k]     = low_cnt[k];
        last_bits[k]    = rx_bits[k];
        last_word[k]    = rx_word[k];
        done_at_rise[k] = dn[k];
        busy_at_rise[k] = bz[k];
        if (rx_bits[k] == 16 && rx_word[k][15:12] == 4'h1)
          conf[k] = rx_word[k][7:0];
        frames[k]++;
        high_cnt[k] = 1;
      end else if (nc[k] === 1'b1) begin
        high_cnt[k]++;
      end
      if (dn[k] === 1'b1) begin
        chk($sformatf("done_with_ncs_rise[%0d]", k), 32'(nc[k] && !pnc[k]), 32'd1);
        done_cyc[k]  = cyc;
        have_done[k] = 1'b1;
      end
      psp[k] = sp[k];
      pmo[k] = mo[k];
      pnc[k] = nc[k];
    end
  end

  logic [7:0] model_conf[2] = '{8'd0, 8'd0};

  task automatic drive(input int k, input logic v, input logic [15:0] wd);
    if (k == 0) begin
      bus_a.cmd_valid = v;
      bus_a.cmd_word  = wd;
    end else begin
      bus_b.cmd_valid = v;
      bus_b.cmd_word  = wd;
    end
  endtask

  task automatic wait_acc(input int k, input int n0, input string tag);
    for (int i = 0; i < 500 && acc_cnt[k] == n0; i++) @(negedge pck0);
    chk(tag, 32'(acc_cnt[k]), 32'(n0 + 1));
  endtask

  task automatic wait_frame(input int k, input int f_target, input string tag);
    for (int i = 0; i < 3000 && frames[k] < f_target; i++) @(negedge pck0);
    chk(tag, 32'(frames[k]), 32'(f_target));
  endtask

  task automatic send(input int k, input logic [15:0] wd, input int gap);
    int a0, f0;
    repeat (gap + 1) @(posedge pck0);
    #1;
    a0 = acc_cnt[k];
    f0 = frames[k];
    drive(k, 1'b1, wd);
    wait_acc(k, a0, "accept");
    @(posedge pck0);
    #1;
    drive(k, 1'b0, 16'($urandom));
    chk("busy_after_accept", 32'(bz[k]), 32'd1);
    chk("ready_after_accept", 32'(rdy[k]), 32'd0);
    if (wd[15:12] == 4'h1) model_conf[k] = wd[7:0];
    wait_frame(k, f0 + 1, "frame_end");
    chk("ncs_low_len", 32'(last_low[k]), 32'(34 * div_k[k]));
    chk("rx_word", 32'(last_word[k]), 32'(wd));
    chk("spck_rises", 32'(last_bits[k]), 32'd16);
    chk("done_at_ncs_rise", 32'(done_at_rise[k]), 32'd1);
    chk("busy_at_ncs_rise", 32'(busy_at_rise[k]), 32'd1);
    chk("conf_word", 32'(conf[k]), 32'(model_conf[k]));
    repeat (idle_k[k] + 2) @(posedge pck0);
    #1;
    chk("ready_after_gap", 32'(rdy[k]), 32'd1);
    chk("busy_after_gap", 32'(bz[k]), 32'd0);
    chk("accepts_per_frame", 32'(acc_cnt[k]), 32'(a0 + 1));
  endtask

  initial begin
    int a0, f0;
    logic [15:0] w, w2;
    logic [7:0] conf_before;

    reset_a = 1'b1;
    reset_b = 1'b1;
    drive(0, 1'b0, 16'd0);
    drive(1, 1'b0, 16'd0);
    repeat (3) @(posedge pck0);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_ncs", 32'(nc[k]), 32'd1);
      chk("rst_spck", 32'(sp[k]), 32'd0);
      chk("rst_mosi", 32'(mo[k]), 32'd0);
      chk("rst_busy", 32'(bz[k]), 32'd0);
      chk("rst_done", 32'(dn[k]), 32'd0);
      chk("rst_ready", 32'(rdy[k]), 32'd0);
    end
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(posedge pck0);
    #1;
    chk("ready_after_reset_a", 32'(rdy[0]), 32'd1);
    chk("ready_after_reset_b", 32'(rdy[1]), 32'd1);

    send(0, 16'h1043, 0);
    chk("t1_conf_43", 32'(conf[0]), 32'h43);

    a0 = acc_cnt[0];
    f0 = frames[0];
    drive(0, 1'b1, 16'h10A5);
    wait_acc(0, a0, "t2_accept1");
    @(posedge pck0);
    #1;
    drive(0, 1'b1, 16'h10FF);
    wait_acc(0, a0 + 1, "t2_accept2");
    chk("t2_back_to_back_spacing", 32'(gap_acc[0]), 32'd9);
    @(posedge pck0);
    #1;
    drive(0, 1'b0, 16'h0000);
    wait_frame(0, f0 + 2, "t2_frames");
    model_conf[0] = 8'hFF;
    chk("t2_last_word", 32'(last_word[0]), 32'h10FF);
    chk("t2_conf_ff", 32'(conf[0]), 32'hFF);

    repeat (12) @(posedge pck0);
    #1;
    a0 = acc_cnt[0];
    f0 = frames[0];
    drive(0, 1'b1, 16'h1081);
    wait_acc(0, a0, "t3_accept");
    @(posedge pck0);
    #1;
    drive(0, 1'b1, 16'h1000);
    wait_frame(0, f0 + 1, "t3_frame");
    @(posedge pck0);
    #1;
    drive(0, 1'b0, 16'h1000);
    repeat (20) @(posedge pck0);
    #1;
    model_conf[0] = 8'h81;
    chk("t3_no_extra_accept", 32'(acc_cnt[0]), 32'(a0 + 1));
    chk("t3_rx_word", 32'(last_word[0]), 32'h1081);
    chk("t3_conf_81", 32'(conf[0]), 32'h81);

    for (int i = 0; i < 6; i++) begin
      w[15:12] = ($urandom_range(0, 1) == 1) ? 4'h1 : 4'($urandom);
      w[11:0]  = 12'($urandom);
      send(0, w, $urandom_range(0, 5));
    end

    a0 = acc_cnt[0];
    f0 = frames[0];
    conf_before = conf[0];
    w = {4'h1, 12'($urandom)};
    drive(0, 1'b1, w);
    wait_acc(0, a0, "t4_accept");
    @(posedge pck0);
    #1;
    drive(0, 1'b0, 16'h0000);
    for (int i = 0; i < 400 && rx_bits[0] != 5; i++) @(negedge pck0);
    chk("t4_reach_5th_rise", 32'(rx_bits[0]), 32'd5);
    @(posedge pck0);
    #1;
    reset_a = 1'b1;
    @(posedge pck0);
    #1;
    chk("t4_ncs", 32'(nc[0]), 32'd1);
    chk("t4_spck", 32'(sp[0]), 32'd0);
    chk("t4_mosi", 32'(mo[0]), 32'd0);
    chk("t4_done", 32'(dn[0]), 32'd0);
    chk("t4_ready_in_reset", 32'(rdy[0]), 32'd0);
    reset_a = 1'b0;
    @(posedge pck0);
    #1;
    chk("t4_ready_after_release", 32'(rdy[0]), 32'd1);
    chk("t4_partial_frame_bits", 32'(last_bits[0]), 32'd5);
    chk("t4_no_done_on_abort", 32'(done_at_rise[0]), 32'd0);
    chk("t4_conf_kept", 32'(conf[0]), 32'(conf_before));
    send(0, {4'h1, 12'($urandom)}, 0);

    send(1, {4'h1, 12'($urandom)}, 0);
    conf_before = conf[1];
    send(1, 16'h2055, 0);
    chk("t5_conf_unchanged", 32'(conf[1]), 32'(conf_before));

    a0 = acc_cnt[1];
    f0 = frames[1];
    w  = {4'h1, 12'($urandom)};
    w2 = {4'($urandom), 12'($urandom)};
    drive(1, 1'b1, w);
    wait_acc(1, a0, "b2b_b_accept1");
    @(posedge pck0);
    #1;
    drive(1, 1'b1, w2);
    wait_acc(1, a0 + 1, "b2b_b_accept2");
    chk("b2b_b_spacing", 32'(gap_acc[1]), 32'd2);
    @(posedge pck0);
    #1;
    drive(1, 1'b0, 16'h0000);
    wait_frame(1, f0 + 2, "b2b_b_frames");
    model_conf[1] = (w2[15:12] == 4'h1) ? w2[7:0] : w[7:0];
    chk("b2b_b_last_word", 32'(last_word[1]), 32'(w2));
    chk("b2b_b_conf", 32'(conf[1]), 32'(model_conf[1]));
    repeat (5) @(posedge pck0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
